// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO used to stage DATA_WIDTH-bit words between a producer and
// a consumer that share one clock. Read data is registered, so a word
// appears on data_out one cycle after the edge that accepts the read.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (0 = reset)
//   data_in      write data, captured when a write is accepted
//   wr_en        write request
//   rd_en        read request
//   data_out     registered read data; holds its value when no read is accepted
//   f_empty      FIFO holds zero entries
//   f_full       FIFO holds DEPTH entries
//   almost_full  count >= ALMOST_FULL_TH
//   almost_empty count <= ALMOST_EMPTY_TH
//   count        current occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a write was rejected because the FIFO was full
//   underflow    one-cycle pulse after a read was rejected because the FIFO was empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_TH  = DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  f_empty,
    output logic                  f_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Thresholds sized to the count register so the flag compares are width-matched.
    localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT   = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT   = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags are pure functions of the registered count.
    assign f_empty      = (count == '0);
    assign f_full       = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A full FIFO can still take a write when a read frees a slot in the same
    // cycle; an empty FIFO never forwards a same-cycle write to the read side.
    assign rd_accept = rd_en && !f_empty;
    assign wr_accept = wr_en && (!f_full || rd_accept);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (rd_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end

            unique case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; stale words are
    // unreachable because the pointers and count are cleared, and an unreset
    // array maps onto plain RAM instead of a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Self-checking bench for sync_fifo. A queue-based reference model tracks the
// FIFO contents; every cycle all outputs are compared with values derived
// from that queue. Directed sequences cover reset, fill, drain, overflow,
// underflow, wrap-around and simultaneous access, followed by biased random
// traffic and an asynchronous mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          f_empty;
    logic          f_full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .f_empty      (f_empty),
        .f_full       (f_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output with the model's view of the FIFO.
    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"},        32'(count),        32'(n));
        check({tag, ".f_empty"},      32'(f_empty),      32'(n == 0));
        check({tag, ".f_full"},       32'(f_full),       32'(n == DEPTH));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - 1));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
        check({tag, ".data_out"},     32'(data_out),     32'(exp_dout));
        check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(exp_unf));
    endtask

    // One clock: drive on the falling edge, update the model with the
    // pre-edge occupancy, then check #1 after the rising edge.
    task automatic cycle(input string tag, input logic wr, input logic rd, input logic [DW-1:0] din);
        bit full_now, empty_now, rd_ok, wr_ok;
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        full_now  = (model_q.size() == DEPTH);
        empty_now = (model_q.size() == 0);
        rd_ok = rd && !empty_now;
        wr_ok = wr && (!full_now || rd_ok);
        if (rd_ok) exp_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        exp_ovf = wr && !wr_ok;
        exp_unf = rd && !rd_ok;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Fill 0..7, then one rejected write of AA.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'(i));
        cycle("ovf", 1'b1, 1'b0, 8'hAA);
        cycle("ovf_clear", 1'b0, 1'b0, 8'h00);

        // Drain 0..7, then one rejected read.
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
        cycle("unf", 1'b0, 1'b1, 8'h00);
        cycle("unf_clear", 1'b0, 1'b0, 8'h00);

        // Wrap-around: shift pointers by 5, then fill across the boundary.
        for (int i = 0; i < 5; i++) cycle("wrap_pre_wr", 1'b1, 1'b0, DW'(8'h50 + i));
        for (int i = 0; i < 5; i++) cycle("wrap_pre_rd", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle("wrap_fill", 1'b1, 1'b0, DW'(8'h10 + i));

        // Simultaneous read+write while full, then drain to see the new word last.
        cycle("full_both", 1'b1, 1'b1, 8'hC3);
        for (int i = 0; i < DEPTH; i++) cycle("full_both_drain", 1'b0, 1'b1, 8'h00);

        // Simultaneous read+write while empty: write lands, read is rejected.
        cycle("empty_both", 1'b1, 1'b1, 8'h5A);
        cycle("empty_both_rd", 1'b0, 1'b1, 8'h00);

        // Biased random traffic: write-heavy, read-heavy and balanced phases.
        for (int phase = 0; phase < 6; phase++) begin
            int pw, pr;
            pw = (phase % 3 == 0) ? 80 : (phase % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 200; i++) begin
                cycle("rand", ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                      DW'($urandom));
            end
        end

        // Asynchronous reset mid-cycle with five entries stored.
        while (model_q.size() > 0) cycle("pre_arst_drain", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle("pre_arst_fill", 1'b1, 1'b0, DW'(8'h30 + i));
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst.count", 32'(count), 32'd0);
        check("arst.f_empty", 32'(f_empty), 32'd1);
        model_reset();
        check_all("arst");
        @(negedge clk);
        rst = 1'b1;

        // Stored data must be gone after the reset.
        cycle("post_arst_rd", 1'b0, 1'b1, 8'h00);
        cycle("post_arst_wr", 1'b1, 1'b0, 8'h77);
        cycle("post_arst_rd2", 1'b0, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
